// File: rtl/elastic_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_pkg
// Brief    : Shared constants and elaboration helpers for elastic_pipeline.
// Revision : 1.0  initial release
// ============================================================================
package elastic_pipe_pkg;

    localparam int MAX_STAGES = 16;

    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit params_legal(input int num_stages, input int data_width);
        return (num_stages >= 1) && (num_stages <= MAX_STAGES) && (data_width >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_if
// Brief    : Producer/consumer handshake bundle around the elastic pipeline.
// Revision : 1.0  initial release
// ============================================================================
interface elastic_pipe_if
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OCC_WIDTH  = occ_width(3)
) ();

    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [OCC_WIDTH-1:0]  occupancy;

    // master is the surrounding logic (producer + consumer), slave is the pipeline
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_stage
// Brief    : One valid/payload register pair with load, hold and flush.
// Revision : 1.0  initial release
// ============================================================================
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit RESET_DATA = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_flush,
    input  wire logic                  i_load,
    input  wire logic                  i_valid,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_valid,
    output logic                       o_valid_nxt,
    output logic [DATA_WIDTH-1:0]      o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_valid_nxt;
    logic                  w_write;

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
        end else if (i_load) begin
            w_valid_nxt = i_valid;
        end
    end

    // Bubbles and flushes never touch the payload, only the valid bit.
    assign w_write = i_load & i_valid & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    if (RESET_DATA) begin : g_data_rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
            end else if (w_write) begin
                r_data <= i_data;
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk) begin
            if (w_write) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_data      = r_data;

endmodule
`default_nettype wire

// File: rtl/elastic_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipeline
// Brief    : NUM_STAGES-deep valid/ready register pipeline with flush and
//            registered occupancy count.
// Revision : 1.0  initial release
// ============================================================================
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int DATA_WIDTH = 16,
    parameter bit RESET_DATA = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    elastic_pipe_if.slave bus
);

    localparam int c_occ_width = occ_width(NUM_STAGES);

    if (!params_legal(NUM_STAGES, DATA_WIDTH)) begin : g_param_check
        $error("elastic_pipeline: NUM_STAGES must be 1..%0d and DATA_WIDTH >= 1", MAX_STAGES);
    end

    logic [NUM_STAGES-1:0]  w_v;
    logic [NUM_STAGES-1:0]  w_v_nxt;
    logic [NUM_STAGES-1:0]  w_rdy;
    logic [NUM_STAGES-1:0]  w_up_v;
    logic [DATA_WIDTH-1:0]  w_up_d [NUM_STAGES];
    logic [DATA_WIDTH-1:0]  w_d    [NUM_STAGES];
    logic [c_occ_width-1:0] w_occ_nxt;
    logic [c_occ_width-1:0] r_occ;

    // Ready ripples combinationally from out_ready back to in_ready through
    // every stage: this chain is the critical timing path for deep pipelines.
    always_comb begin
        w_rdy = '0;
        w_rdy[NUM_STAGES-1] = ~w_v[NUM_STAGES-1] | bus.out_ready;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_rdy[i] = ~w_v[i] | w_rdy[i+1];
        end
    end

    always_comb begin
        w_up_v    = '0;
        w_up_v[0] = bus.in_valid;
        w_up_d[0] = bus.in_data;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_up_v[i] = w_v[i-1];
            w_up_d[i] = w_d[i-1];
        end
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        elastic_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (bus.flush),
            .i_load      (w_rdy[i]),
            .i_valid     (w_up_v[i]),
            .i_data      (w_up_d[i]),
            .o_valid     (w_v[i]),
            .o_valid_nxt (w_v_nxt[i]),
            .o_data      (w_d[i])
        );
    end

    // Counting the next-state valids keeps occupancy aligned with v after each edge.
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_occ_nxt = w_occ_nxt + c_occ_width'(w_v_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    assign bus.in_ready  = w_rdy[0] & ~bus.flush;
    assign bus.out_valid = w_v[NUM_STAGES-1];
    assign bus.out_data  = w_d[NUM_STAGES-1];
    assign bus.occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_pipeline
// Brief    : Self-checking bench: vector table, scoreboard and corner sequences.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_elastic_pipeline;
    import elastic_pipe_pkg::*;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int OW = occ_width(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elastic_pipe_if #(.DATA_WIDTH(W), .OCC_WIDTH(OW)) bus ();

    elastic_pipeline #(
        .NUM_STAGES (N),
        .DATA_WIDTH (W),
        .RESET_DATA (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          iv;
        logic [W-1:0]  id;
        logic          ordy;
        logic          fl;
        logic          ir;
        logic          ov;
        logic [W-1:0]  od;
        logic [OW-1:0] occ;
    } vec_t;

    vec_t         tbl [19];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] sb_exp;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfers are observed on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, hold_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got %0h expected no output", bus.out_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_data", bus.out_data, sb_exp);
                end
            end
            if (bus.flush) begin
                sb_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(bus.in_data);
            end
            hold_prev = bus.out_valid && !bus.out_ready && !bus.flush;
            hold_data = bus.out_data;
        end
    end

    initial begin
        //            iv    id        ordy  fl    ir    ov    od        occ
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
        tbl[1]  = '{1'b1, 16'hA000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
        tbl[2]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
        tbl[3]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2};
        tbl[4]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 2'd3};
        tbl[5]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 2'd3};
        tbl[6]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA000, 2'd3};
        tbl[7]  = '{1'b1, 16'hA004, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA001, 2'd3};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA002, 2'd3};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA003, 2'd2};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA004, 2'd1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA004, 2'd0};
        tbl[12] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA004, 2'd0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA004, 2'd1};
        tbl[14] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA004, 2'd1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 2'd2};
        tbl[16] = '{1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 2'd2};
        tbl[17] = '{1'b1, 16'h00CC, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0011, 2'd3};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 2'd0};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_occupancy", bus.occupancy, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_data", bus.out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill under backpressure, drain, bubble collapse, flush while full.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            #1;
            chk($sformatf("row%0d_in_ready", i), bus.in_ready, tbl[i].ir);
            chk($sformatf("row%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            chk($sformatf("row%0d_out_data", i), bus.out_data, tbl[i].od);
            chk($sformatf("row%0d_occupancy", i), bus.occupancy, tbl[i].occ);
            tick();
        end

        // Back-to-back streaming of 0x0001..0x0010.
        for (int c = 0; c < 22; c++) begin
            if (c < 16) drive(1'b1, 16'(c + 1), 1'b1, 1'b0);
            else        drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            if (c < N) chk($sformatf("stream_c%0d_early_valid", c), bus.out_valid, 0);
            if (c >= N && c < N + 16) begin
                chk($sformatf("stream_c%0d_valid", c), bus.out_valid, 1);
                chk($sformatf("stream_c%0d_data", c), bus.out_data, 64'(c - N + 1));
            end
            if (c >= N && c <= 16) chk($sformatf("stream_c%0d_occ", c), bus.occupancy, N);
            tick();
        end

        // Flush a full pipeline while a new word is offered.
        drive(1'b1, 16'h00B1, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h00B2, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h00B3, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h00CC, 1'b1, 1'b1);
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_occ_before", bus.occupancy, N);
        chk("flush_out_data", bus.out_data, 16'h00B1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("flush_occ_after", bus.occupancy, 0);
        chk("flush_out_valid_after", bus.out_valid, 0);
        repeat (4) tick();
        chk("flush_no_leak", bus.out_valid, 0);

        // Asynchronous reset between edges while traffic is in flight.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'(16'h0100 + k), 1'b1, 1'b0);
            tick();
        end
        chk("pre_rst_occ", bus.occupancy, N);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_occ", bus.occupancy, 0);
        chk("async_rst_in_ready", bus.in_ready, 1);
        repeat (2) tick();
        rst = 1'b0;
        drive(1'b1, 16'h5A5A, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (N - 2) tick();
        chk("post_rst_not_yet", bus.out_valid, 0);
        tick();
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_data", bus.out_data, 16'h5A5A);
        tick();

        // Random valid/ready with occasional flush; scoreboard and hold checks run throughout.
        for (int c = 0; c < 4000; c++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (N + 2) tick();
        chk("drain_sb_empty", 64'(sb_q.size()), 0);
        chk("drain_occ", bus.occupancy, 0);
        chk("drain_out_valid", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
